// File: rtl/jt12_pkg.sv
// Shared constants and types for the FM operator slot sequencer.
package jt12_pkg;

  localparam int unsigned ALG_W  = 3;
  localparam int unsigned FB_W   = 3;
  localparam int unsigned SLOT_W = 2;

  // Slot group encoding, in the order the sequencer visits them
  localparam logic [SLOT_W-1:0] S1 = 2'd0;
  localparam logic [SLOT_W-1:0] S3 = 2'd1;
  localparam logic [SLOT_W-1:0] S2 = 2'd2;
  localparam logic [SLOT_W-1:0] S4 = 2'd3;

  typedef struct packed {
    logic xuse_prevprev1;
    logic xuse_prev2;
    logic xuse_internal;
    logic yuse_prev1;
    logic yuse_prev2;
    logic yuse_internal;
    logic carrier;
  } route_t;

endpackage

// File: rtl/jt12_route_dec.sv
// Combinational decode of (slot, algorithm) into modulation selects and carrier flag.
module jt12_route_dec
  import jt12_pkg::*;
(
  input  logic [SLOT_W-1:0] slot,
  input  logic [ALG_W-1:0]  alg,
  output route_t            route
);

  always_comb begin
    route = '0;
    case (slot)
      S1: begin
        // Self-feedback path is the same for every algorithm
        route.xuse_prevprev1 = 1'b1;
        route.yuse_prev1     = 1'b1;
        route.carrier        = (alg == 3'd7);
      end
      S3: begin
        route.xuse_internal = alg inside {3'd0, 3'd1, 3'd2};
        route.yuse_prev1    = alg inside {3'd1, 3'd5};
        route.carrier       = (alg >= 3'd5);
      end
      S2: begin
        route.xuse_internal = alg inside {3'd0, 3'd3, 3'd4, 3'd5, 3'd6};
        route.carrier       = (alg >= 3'd4);
      end
      default: begin
        route.xuse_internal = alg inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        route.yuse_prev1    = alg inside {3'd2, 3'd5};
        route.yuse_prev2    = (alg == 3'd3);
        route.carrier       = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/jt12_op_sched.sv
// Slot sequencer and modulation router for the shared FM operator pipeline.
module jt12_op_sched
  import jt12_pkg::*;
#(
  parameter int unsigned num_ch = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_ch,
  input  logic [ALG_W-1:0] cfg_alg,
  input  logic [FB_W-1:0]  cfg_fb,
  output logic             s1_enters,
  output logic             s2_enters,
  output logic             s3_enters,
  output logic             s4_enters,
  output logic             zero,
  output logic [2:0]       cur_ch,
  output logic             xuse_prevprev1,
  output logic             xuse_prev2,
  output logic             xuse_internal,
  output logic             yuse_prev1,
  output logic             yuse_prev2,
  output logic             yuse_internal,
  output logic [FB_W-1:0]  fb_II,
  output logic             carrier
);

  localparam int unsigned CH_W   = 3;
  localparam int unsigned CH_MAX = 8;

  // Slot counter split as group (which is also the slot code) and channel
  logic [SLOT_W-1:0] grp_cnt;
  logic [CH_W-1:0]   ch_cnt;

  logic [ALG_W-1:0] alg_r [CH_MAX];
  logic [FB_W-1:0]  fb_r  [CH_MAX];
  logic [FB_W-1:0]  fb_I;

  logic [ALG_W-1:0] cur_alg_c;
  route_t           route_c;

  assign cur_alg_c = alg_r[ch_cnt];

  jt12_route_dec u_route_dec (
    .slot  (grp_cnt),
    .alg   (cur_alg_c),
    .route (route_c)
  );

  // Per-channel config; writes ignore clk_en and out-of-range channels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_MAX; i++) begin
        alg_r[i] <= '0;
        fb_r[i]  <= '0;
      end
    end else if (cfg_we && (32'(cfg_ch) < num_ch)) begin
      alg_r[cfg_ch] <= cfg_alg;
      fb_r[cfg_ch]  <= cfg_fb;
    end
  end

  // Free-running slot counter; group wraps 3->0 naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_cnt <= '0;
      ch_cnt  <= '0;
    end else if (clk_en) begin
      if (ch_cnt == CH_W'(num_ch - 1)) begin
        ch_cnt  <= '0;
        grp_cnt <= grp_cnt + SLOT_W'(1);
      end else begin
        ch_cnt <= ch_cnt + CH_W'(1);
      end
    end
  end

  // Registered slot outputs, one enabled cycle behind the counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_enters      <= 1'b0;
      s2_enters      <= 1'b0;
      s3_enters      <= 1'b0;
      s4_enters      <= 1'b0;
      zero           <= 1'b0;
      cur_ch         <= '0;
      xuse_prevprev1 <= 1'b0;
      xuse_prev2     <= 1'b0;
      xuse_internal  <= 1'b0;
      yuse_prev1     <= 1'b0;
      yuse_prev2     <= 1'b0;
      yuse_internal  <= 1'b0;
      carrier        <= 1'b0;
      fb_I           <= '0;
      fb_II          <= '0;
    end else if (clk_en) begin
      s1_enters      <= (grp_cnt == S1);
      s2_enters      <= (grp_cnt == S2);
      s3_enters      <= (grp_cnt == S3);
      s4_enters      <= (grp_cnt == S4);
      zero           <= (grp_cnt == S1) && (ch_cnt == '0);
      cur_ch         <= ch_cnt;
      xuse_prevprev1 <= route_c.xuse_prevprev1;
      xuse_prev2     <= route_c.xuse_prev2;
      xuse_internal  <= route_c.xuse_internal;
      yuse_prev1     <= route_c.yuse_prev1;
      yuse_prev2     <= route_c.yuse_prev2;
      yuse_internal  <= route_c.yuse_internal;
      carrier        <= route_c.carrier;
      // Feedback rides one stage deeper, only for S1 slots
      fb_I           <= (grp_cnt == S1) ? fb_r[ch_cnt] : '0;
      fb_II          <= fb_I;
    end
  end

endmodule

// File: tb/tb_jt12_op_sched.sv
// Directed self-checking bench for jt12_op_sched with num_ch = 6.
module tb_jt12_op_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_en;
  logic       cfg_we;
  logic [2:0] cfg_ch;
  logic [2:0] cfg_alg;
  logic [2:0] cfg_fb;
  logic       s1_enters, s2_enters, s3_enters, s4_enters;
  logic       zero;
  logic [2:0] cur_ch;
  logic       xuse_prevprev1, xuse_prev2, xuse_internal;
  logic       yuse_prev1, yuse_prev2, yuse_internal;
  logic [2:0] fb_II;
  logic       carrier;

  int n_checks = 0;
  int n_errors = 0;

  // Strobes packed as {s1,s2,s3,s4}; selects as {xpp1,xp2,xint,yp1,yp2,yint,carrier}
  localparam logic [3:0] ST_S1 = 4'b1000;
  localparam logic [3:0] ST_S3 = 4'b0010;
  localparam logic [3:0] ST_S2 = 4'b0100;
  localparam logic [3:0] ST_S4 = 4'b0001;

  logic [3:0]  strobes;
  logic [6:0]  sel;
  logic [17:0] all_out;
  logic [3:0]  grp_st [4];
  logic [6:0]  sel_alg0 [4];

  assign strobes = {s1_enters, s2_enters, s3_enters, s4_enters};
  assign sel = {xuse_prevprev1, xuse_prev2, xuse_internal,
                yuse_prev1, yuse_prev2, yuse_internal, carrier};
  assign all_out = {strobes, zero, cur_ch, sel, fb_II};

  jt12_op_sched #(.num_ch(6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clk_en         (clk_en),
    .cfg_we         (cfg_we),
    .cfg_ch         (cfg_ch),
    .cfg_alg        (cfg_alg),
    .cfg_fb         (cfg_fb),
    .s1_enters      (s1_enters),
    .s2_enters      (s2_enters),
    .s3_enters      (s3_enters),
    .s4_enters      (s4_enters),
    .zero           (zero),
    .cur_ch         (cur_ch),
    .xuse_prevprev1 (xuse_prevprev1),
    .xuse_prev2     (xuse_prev2),
    .xuse_internal  (xuse_internal),
    .yuse_prev1     (yuse_prev1),
    .yuse_prev2     (yuse_prev2),
    .yuse_internal  (yuse_internal),
    .fb_II          (fb_II),
    .carrier        (carrier)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_slot(input logic [3:0] st, input logic [2:0] ch);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (strobes == st && cur_ch == ch) found = 1'b1;
    end
    check("wait_slot", 32'(found), 32'd1);
  endtask

  task automatic cfg_write(input logic [2:0] ch, input logic [2:0] alg, input logic [2:0] fb);
    cfg_we = 1'b1; cfg_ch = ch; cfg_alg = alg; cfg_fb = fb;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    int n;
    logic [3:0] e_st;
    logic [2:0] e_ch;
    logic       e_zero;

    grp_st   = '{ST_S1, ST_S3, ST_S2, ST_S4};
    sel_alg0 = '{7'b1001000, 7'b0010000, 7'b0010000, 7'b0010001};
    rst_n = 1'b0; clk_en = 1'b0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_alg = '0; cfg_fb = '0;

    // Reset and first frame
    #12;
    check("reset_outputs", 32'(all_out), 32'd0);
    rst_n = 1'b1;
    clk_en = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      check("frame_strobe", 32'(strobes), 32'(grp_st[((k - 1) / 6) % 4]));
      check("frame_ch",     32'(cur_ch),  32'((k - 1) % 6));
      check("frame_zero",   32'(zero),    32'(k == 1 || k == 25));
      check("frame_sel",    32'(sel),     32'(sel_alg0[((k - 1) / 6) % 4]));
    end

    // Routing for alg 3 on ch2
    cfg_write(3'd2, 3'd3, 3'd0);
    wait_slot(ST_S3, 3'd2);
    check("alg3_s3_sel", 32'(sel), 32'b0000000);
    wait_slot(ST_S2, 3'd2);
    check("alg3_s2_sel", 32'(sel), 32'b0010000);
    wait_slot(ST_S4, 3'd2);
    check("alg3_s4_sel", 32'(sel), 32'b0010101);
    wait_slot(ST_S1, 3'd2);
    check("alg3_s1_sel", 32'(sel), 32'b1001000);

    // Feedback alignment on ch4
    cfg_write(3'd4, 3'd0, 3'd5);
    wait_slot(ST_S1, 3'd4);
    check("fb_at_s1", 32'(fb_II), 32'd0);
    step();
    check("fb_next",  32'(fb_II), 32'd5);
    step();
    check("fb_after", 32'(fb_II), 32'd0);

    // Enable gating, 1-in-3, from a fresh reset
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 45; i++) begin
      clk_en = (i % 3 == 0);
      step();
      if (i % 3 == 0) n++;
      if (n == 0) begin
        e_st = 4'b0000; e_ch = 3'd0; e_zero = 1'b0;
      end else begin
        e_st   = grp_st[((n - 1) / 6) % 4];
        e_ch   = 3'((n - 1) % 6);
        e_zero = ((n - 1) % 24 == 0);
      end
      check("gate_strobe", 32'(strobes), 32'(e_st));
      check("gate_ch",     32'(cur_ch),  32'(e_ch));
      check("gate_zero",   32'(zero),    32'(e_zero));
    end
    clk_en = 1'b1;

    // Write collision on ch0: decode at S1 ch0 sees old alg 7
    cfg_write(3'd0, 3'd7, 3'd0);
    wait_slot(ST_S4, 3'd5);
    cfg_we = 1'b1; cfg_ch = 3'd0; cfg_alg = 3'd0; cfg_fb = 3'd0;
    step();
    cfg_we = 1'b0;
    check("coll_strobe", 32'(strobes), 32'(ST_S1));
    check("coll_ch",     32'(cur_ch),  32'd0);
    check("coll_s1_sel", 32'(sel),     32'b1001001);
    wait_slot(ST_S3, 3'd0);
    check("coll_s3_sel", 32'(sel),     32'b0010000);

    // Async reset mid-frame at slot 15 (S2 ch3)
    wait_slot(ST_S2, 3'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_clear", 32'(all_out), 32'd0);
    step();
    check("reset_hold", 32'(all_out), 32'd0);
    rst_n = 1'b1;
    cfg_we = 1'b1; cfg_ch = 3'd6; cfg_alg = 3'd7; cfg_fb = 3'd7;
    step();
    check("rel_strobe", 32'(strobes), 32'(ST_S1));
    check("rel_ch",     32'(cur_ch),  32'd0);
    check("rel_zero",   32'(zero),    32'd1);
    check("rel_sel",    32'(sel),     32'b1001000);
    cfg_ch = 3'd7;
    step();
    cfg_we = 1'b0;
    for (int c = 1; c < 6; c++) begin
      if (c > 1) step();
      check("oor_ch",  32'(cur_ch), 32'(c));
      check("oor_sel", 32'(sel),    32'b1001000);
      check("oor_fb",  32'(fb_II),  32'd0);
    end
    step();
    check("oor_fb_ch5", 32'(fb_II), 32'd0);
    check("oor_s3",     32'(strobes), 32'(ST_S3));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
